// File: rtl/video_scale_line_packer.sv
// Packs the scaler's RGB888 pixels into RGB565, 8 per 128-bit word, and queues line words with SOF/EOL flags.
// Latency: a word pushed into an empty FIFO appears on wr_dat/wr_valid two cycles after the push.
// Backpressure: wr_ready stalls the FIFO; pix_ready drops at AFULL_MARGIN free words, pixels offered anyway are dropped and flagged.
// Build option VPACK_DROP_CNT_EN adds a saturating drop_cnt[15:0] output.
module video_scale_line_packer #(
    parameter int FIFO_DEPTH   = 64,
    parameter int AFULL_MARGIN = 4
) (
    input  logic         vin_clk,
    input  logic         rst_n,
    input  logic         frame_vs,
    input  logic [24:0]  pix_dat,
    input  logic         pix_valid,
    output logic         pix_ready,
    input  logic [15:0]  vout_xres,
    input  logic [15:0]  vout_yres,
    output logic [127:0] wr_dat,
    output logic         wr_valid,
    input  logic         wr_ready,
    output logic         wr_sof,
    output logic         wr_eol,
`ifdef VPACK_DROP_CNT_EN
    output logic [15:0]  drop_cnt,
`endif
    output logic         ovf_flag
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Occupancy counts memory words plus the output stage; ready only while below this.
    localparam logic [CW-1:0] RDY_LIMIT = CW'(FIFO_DEPTH - AFULL_MARGIN);

    typedef enum logic [1:0] {WAIT_VS = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;
    typedef struct packed {
        logic         sof;
        logic         eol;
        logic [127:0] dat;
    } word_t;

    state_t        state_q, state_d;
    logic          frame_vs_d, vs_rise, run_q;
    logic          accept, drop, push, line_end, last_line;
    logic [15:0]   x_cnt, y_cnt;
    logic [2:0]    slot_q;
    logic [127:0]  pack_q, slot_word;
    logic [15:0]   rgb565;
    logic          sof_pend_q;
    word_t         push_word, out_q;
    word_t         mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] mem_cnt, occ;
    logic          out_vld, load_out;
    logic          unused_pix_bits;

    // Bits discarded by the RGB565 truncation and the scaler's side bit.
    assign unused_pix_bits = ^{pix_dat[24], pix_dat[18:16], pix_dat[9:8], pix_dat[2:0]};

    // Frame sync edge detect; run_q keeps pix_ready low until the first clock after reset.
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_vs_d <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            frame_vs_d <= frame_vs;
            run_q      <= 1'b1;
        end
    end

    assign vs_rise   = frame_vs & ~frame_vs_d;
    assign rgb565    = {pix_dat[23:19], pix_dat[15:10], pix_dat[7:3]};
    assign line_end  = (x_cnt == vout_xres - 16'd1);
    assign last_line = (y_cnt == vout_yres - 16'd1);
    assign slot_word = pack_q | ({112'd0, rgb565} << {slot_q, 4'd0});
    assign push      = accept && ((slot_q == 3'd7) || line_end);
    assign push_word = '{sof: sof_pend_q, eol: line_end, dat: slot_word};
    assign occ       = mem_cnt + CW'(out_vld);

    // State register.
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_VS;
        else        state_q <= state_d;
    end

    // Next state, pixel handshake and drop detection; vs_rise overrides everything.
    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        accept    = 1'b0;
        drop      = 1'b0;
        case (state_q)
            WAIT_VS: pix_ready = run_q;
            ACTIVE: begin
                pix_ready = run_q && (occ < RDY_LIMIT);
                accept    = pix_valid && pix_ready && !vs_rise;
                drop      = pix_valid && !pix_ready && !vs_rise;
                if (accept && line_end && last_line) state_d = DONE;
            end
            DONE:    pix_ready = run_q;
            default: state_d = WAIT_VS;
        endcase
        if (vs_rise) begin
            state_d = ((vout_xres == 16'd0) || (vout_yres == 16'd0)) ? WAIT_VS : ACTIVE;
        end
    end

    // Pack register, slot/line counters, SOF pending and sticky overflow.
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q     <= '0;
            slot_q     <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            sof_pend_q <= 1'b0;
            ovf_flag   <= 1'b0;
        end else if (vs_rise) begin
            pack_q     <= '0;
            slot_q     <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            sof_pend_q <= 1'b1;
            ovf_flag   <= 1'b0;
        end else begin
            if (accept) begin
                if (push) begin
                    pack_q     <= '0;
                    slot_q     <= '0;
                    sof_pend_q <= 1'b0;
                end else begin
                    pack_q <= slot_word;
                    slot_q <= slot_q + 3'd1;
                end
                if (line_end) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 16'd1;
                end else begin
                    x_cnt <= x_cnt + 16'd1;
                end
            end
            if (drop) ovf_flag <= 1'b1;
        end
    end

    // FIFO storage; push never coincides with vs_rise since accept is masked then.
    always_ff @(posedge vin_clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    // The output stage refills whenever it is empty or being taken, so it holds while stalled.
    assign load_out = (mem_cnt != '0) && (!out_vld || wr_ready);

    // FIFO pointers, count and registered output stage; vs_rise flushes everything.
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (vs_rise) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            out_vld <= 1'b0;
            out_q   <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + AW'(1);
            if (load_out) rd_ptr <= rd_ptr + AW'(1);
            mem_cnt <= mem_cnt + CW'(push) - CW'(load_out);
            if (load_out) begin
                out_q   <= mem[rd_ptr];
                out_vld <= 1'b1;
            end else if (out_vld && wr_ready) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign wr_valid = out_vld;
    assign wr_dat   = out_q.dat;
    assign wr_sof   = out_q.sof;
    assign wr_eol   = out_q.eol;

`ifdef VPACK_DROP_CNT_EN
    // Saturating count of pixels dropped in ACTIVE.
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n)                                 drop_cnt <= '0;
        else if (vs_rise)                           drop_cnt <= '0;
        else if (drop && (drop_cnt != 16'hFFFF))    drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_video_scale_line_packer.sv
// Testbench for video_scale_line_packer: directed frames plus random pixel/back-pressure frames.
// Expected words are rebuilt from the list of accepted pixels (line/chunk arithmetic) and compared in order.
// Also covers reset values, frame-sync flush, FIFO-full dropping and post-frame discard.
module tb_video_scale_line_packer;

    logic         vin_clk = 1'b0;
    logic         rst_n;
    logic         frame_vs;
    logic [24:0]  pix_dat;
    logic         pix_valid;
    logic         pix_ready;
    logic [15:0]  vout_xres;
    logic [15:0]  vout_yres;
    logic [127:0] wr_dat;
    logic         wr_valid;
    logic         wr_ready;
    logic         wr_sof;
    logic         wr_eol;
    logic         ovf_flag;
`ifdef VPACK_DROP_CNT_EN
    logic [15:0]  drop_cnt;
`endif

    video_scale_line_packer dut (
        .vin_clk   (vin_clk),
        .rst_n     (rst_n),
        .frame_vs  (frame_vs),
        .pix_dat   (pix_dat),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .vout_xres (vout_xres),
        .vout_yres (vout_yres),
        .wr_dat    (wr_dat),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_sof    (wr_sof),
        .wr_eol    (wr_eol),
`ifdef VPACK_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .ovf_flag  (ovf_flag)
    );

    always #5 vin_clk = ~vin_clk;

    int           checks = 0;
    int           errors = 0;
    logic [23:0]  acc_q[$];
    logic [129:0] got_q[$];
    logic [129:0] exp_q[$];
    bit           frame_on = 0;
    bit           in_vs = 0;
    int           cur_xr = 0;
    int           cur_yr = 0;
    int           drops = 0;

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    // One clock: sample handshakes on the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge vin_clk);
        if (rst_n && !in_vs && frame_on && pix_valid) begin
            if (pix_ready) begin
                acc_q.push_back(pix_dat[23:0]);
                if (acc_q.size() == cur_xr * cur_yr) frame_on = 0;
            end else begin
                drops++;
            end
        end
        if (wr_valid && wr_ready) got_q.push_back({wr_sof, wr_eol, wr_dat});
        @(posedge vin_clk);
        #1;
    endtask

    // Raise frame_vs for one cycle with a junk pixel offered in the edge cycle.
    task automatic start_frame(input int xr, input int yr);
        vout_xres = 16'(xr);
        vout_yres = 16'(yr);
        frame_vs  = 1'b1;
        pix_valid = 1'b1;
        pix_dat   = 25'($urandom());
        in_vs     = 1;
        tick();
        in_vs     = 0;
        frame_vs  = 1'b0;
        pix_valid = 1'b0;
        acc_q.delete();
        got_q.delete();
        cur_xr    = xr;
        cur_yr    = yr;
        frame_on  = (xr != 0) && (yr != 0);
        drops     = 0;
    endtask

    task automatic feed(input int target, input int vpct, input int rpct, input int budget);
        int cyc;
        cyc = 0;
        while (acc_q.size() < target && cyc < budget) begin
            pix_valid = ($urandom_range(99) < vpct);
            pix_dat   = 25'($urandom());
            wr_ready  = ($urandom_range(99) < rpct);
            tick();
            cyc++;
        end
        pix_valid = 1'b0;
        chk("feed_budget", 130'(acc_q.size() >= target), 130'd1);
    endtask

    task automatic drain(input int n);
        pix_valid = 1'b0;
        wr_ready  = 1'b1;
        repeat (n) tick();
    endtask

    // Every line is split into 8-pixel chunks; a chunk becomes a word once its last pixel is accepted.
    task automatic build_expected(input int xr);
        int n, s, len, base, c;
        bit first;
        logic [129:0] w;
        exp_q.delete();
        n = acc_q.size();
        first = 1;
        for (base = 0; base < n; base += xr) begin
            for (c = 0; c * 8 < xr; c++) begin
                s   = base + c * 8;
                len = (xr - c * 8 > 8) ? 8 : xr - c * 8;
                if (s + len <= n) begin
                    w = '0;
                    for (int k = 0; k < len; k++) w[16*k +: 16] = to565(acc_q[s+k]);
                    w[129] = first;
                    w[128] = (c * 8 + len == xr);
                    first  = 0;
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    task automatic check_frame(input string tag);
        build_expected(cur_xr);
        chk({tag, "_nwords"}, 130'(got_q.size()), 130'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        end
        chk({tag, "_ovf"}, 130'(ovf_flag), 130'(drops > 0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pix_ready"}, 130'(pix_ready), 130'd0);
        chk({tag, "_wr_valid"},  130'(wr_valid),  130'd0);
        chk({tag, "_wr_dat"},    130'(wr_dat),    130'd0);
        chk({tag, "_wr_sof"},    130'(wr_sof),    130'd0);
        chk({tag, "_wr_eol"},    130'(wr_eol),    130'd0);
        chk({tag, "_ovf"},       130'(ovf_flag),  130'd0);
`ifdef VPACK_DROP_CNT_EN
        chk({tag, "_drop_cnt"},  130'(drop_cnt),  130'd0);
`endif
    endtask

    int xr_list[6] = '{1, 7, 8, 9, 23, 33};
    logic [23:0] t3_pix[4] = '{24'hFFFFFF, 24'hF80000, 24'h00FC00, 24'h0000F8};
    logic [15:0] t3_exp[4] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F};

    initial begin
        rst_n     = 1'b0;
        frame_vs  = 1'b0;
        pix_dat   = '0;
        pix_valid = 1'b0;
        wr_ready  = 1'b1;
        vout_xres = 16'd16;
        vout_yres = 16'd2;

        // Reset values, held and just after release.
        repeat (3) @(posedge vin_clk);
        @(negedge vin_clk);
        chk_reset("rst");
        rst_n = 1'b1;
        #1;
        chk("rst_release_pix_ready", 130'(pix_ready), 130'd0);
        @(posedge vin_clk);
        #1;

        // WAIT_VS: pix_ready high, pixels swallowed.
        got_q.delete();
        pix_valid = 1'b1;
        repeat (5) begin
            pix_dat = 25'($urandom());
            tick();
        end
        chk("wait_vs_pix_ready", 130'(pix_ready), 130'd1);
        drain(10);
        chk("wait_vs_no_words", 130'(got_q.size()), 130'd0);

        // T1: two lines of 16.
        start_frame(16, 2);
        feed(32, 100, 100, 100);
        drain(20);
        check_frame("t1");
        if (got_q.size() == 4) begin
            chk("t1_w0_sof_eol", 130'({got_q[0][129], got_q[0][128]}), 130'b10);
            chk("t1_w1_eol",     130'(got_q[1][128]), 130'd1);
            chk("t1_w3_eol",     130'(got_q[3][128]), 130'd1);
        end

        // T6a: pixels after the last line are discarded.
        got_q.delete();
        pix_valid = 1'b1;
        repeat (10) begin
            pix_dat = 25'($urandom());
            tick();
        end
        chk("done_pix_ready", 130'(pix_ready), 130'd1);
        drain(10);
        chk("done_no_words", 130'(got_q.size()), 130'd0);

        // T2: 10-pixel line gives one full and one 2-slot word.
        start_frame(10, 1);
        feed(10, 100, 100, 100);
        drain(20);
        check_frame("t2");
        if (got_q.size() == 2) begin
            chk("t2_w1_pad", 130'(got_q[1][127:32]), 130'd0);
            chk("t2_w1_eol", 130'(got_q[1][128]), 130'd1);
        end

        // T3: colour conversion corners.
        start_frame(4, 1);
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1;
            pix_dat   = {1'b1, t3_pix[i]};
            tick();
        end
        drain(20);
        check_frame("t3");
        if (got_q.size() == 1) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("t3_slot%0d", i), 130'(got_q[0][16*i +: 16]), 130'(t3_exp[i]));
        end

        // Random frames with gaps and back-pressure.
        for (int f = 0; f < 6; f++) begin
            start_frame(xr_list[f], $urandom_range(1, 4));
            feed(cur_xr * cur_yr, 70, 50, 3000);
            drain(80);
            check_frame($sformatf("rnd%0d", f));
        end

        // T4: stalled output fills the FIFO; later pixels drop.
        start_frame(16, 40);
        wr_ready = 1'b0;
        for (int i = 0; i < 600; i++) begin
            pix_valid = 1'b1;
            pix_dat   = 25'($urandom());
            tick();
            if (i == 300) begin
                build_expected(16);
                chk("t4_hold_mid", {wr_sof, wr_eol, wr_dat}, exp_q[0]);
            end
        end
        pix_valid = 1'b0;
        build_expected(16);
        chk("t4_accepted", 130'(acc_q.size()), 130'd480);
        chk("t4_drops",    130'(drops), 130'd120);
        chk("t4_ovf",      130'(ovf_flag), 130'd1);
        chk("t4_pix_ready", 130'(pix_ready), 130'd0);
        chk("t4_wr_valid", 130'(wr_valid), 130'd1);
        chk("t4_hold_end", {wr_sof, wr_eol, wr_dat}, exp_q[0]);
`ifdef VPACK_DROP_CNT_EN
        chk("t4_drop_cnt", 130'(drop_cnt), 130'd120);
`endif

        // T5: frame sync while the FIFO is full flushes it and clears the flag.
        start_frame(20, 2);
        chk("t5_wr_valid", 130'(wr_valid), 130'd0);
        chk("t5_ovf",      130'(ovf_flag), 130'd0);
        chk("t5_pix_ready", 130'(pix_ready), 130'd1);
`ifdef VPACK_DROP_CNT_EN
        chk("t5_drop_cnt", 130'(drop_cnt), 130'd0);
`endif
        // Mid-line frame sync: the new frame starts from slot 0 with SOF.
        feed(12, 100, 0, 100);
        start_frame(20, 2);
        feed(40, 80, 60, 2000);
        drain(40);
        check_frame("t5b");

        // T6b: reset in the middle of a frame.
        start_frame(16, 4);
        feed(20, 100, 0, 100);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        frame_on = 0;
        acc_q.delete();
        got_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pix_valid = 1'b1;
        repeat (8) begin
            pix_dat = 25'($urandom());
            tick();
        end
        chk("midrst_wait_ready", 130'(pix_ready), 130'd1);
        drain(10);
        chk("midrst_no_words", 130'(got_q.size()), 130'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
